// File: rtl/rv32i_types.sv
// Shared RV32I type definitions used by the load path.
//   load_funct3_t : funct3 codes of the integer load instructions
//   load_state_t  : states of the load alignment FSM
//   load_size()   : access size in bytes for a load funct3 code
package rv32i_types;

  typedef enum logic [2:0] {
    FnLb  = 3'b000,
    FnLh  = 3'b001,
    FnLw  = 3'b010,
    FnLbu = 3'b100,
    FnLhu = 3'b101
  } load_funct3_t;

  typedef enum logic [1:0] {
    StIdle,
    StRd0,
    StRd1,
    StDone
  } load_state_t;

  // Reserved codes (3, 6, 7) fall through to a full-word access.
  function automatic logic [2:0] load_size(load_funct3_t funct3);
    case (funct3)
      FnLb, FnLbu: return 3'd1;
      FnLh, FnLhu: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_align_unit_extend.sv
// Combinational shift-and-extend for load data.
//   data_i   : {hi_word, lo_word}; hi_word is zero when the load does not span
//   off_i    : byte offset of the load within lo_word
//   funct3_i : load type, selects width and sign/zero extension
//   data_o   : extended load result
module load_extend
  import rv32i_types::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] data_i,
  input  logic [1:0]        off_i,
  input  load_funct3_t      funct3_i,
  output logic [XLEN-1:0]   data_o
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] field;

  // A byte shift of at most 3 keeps the selected window inside the 64-bit pair.
  assign shamt = {1'b0, off_i, 3'b000};
  assign field = data_i[shamt +: XLEN];

  always_comb begin
    data_o = field;
    case (funct3_i)
      FnLb:    data_o = {{(XLEN - 8){field[7]}}, field[7:0]};
      FnLbu:   data_o = {{(XLEN - 8){1'b0}}, field[7:0]};
      FnLh:    data_o = {{(XLEN - 16){field[15]}}, field[15:0]};
      FnLhu:   data_o = {{(XLEN - 16){1'b0}}, field[15:0]};
      default: data_o = field;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// MEM-stage load unit: accepts one load, issues one or two word-aligned cache
// reads, then returns the aligned and extended result as a one-cycle pulse.
//   clk_i/rst_ni                     : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o          : request handshake (ready only when idle)
//   req_addr_i/req_funct3_i          : byte address and load type
//   mem_read_o/mem_addr_o            : word-aligned read strobe and address
//   mem_rdata_i/mem_resp_i           : read data, valid with the response strobe
//   rsp_valid_o/rsp_data_o           : result pulse and extended data
//   rsp_misaligned_o                 : word-crossing load trapped (MISALIGNED_EN=0)
//   busy_o                           : unit is not idle; pipeline must stall
module load_align_unit
  import rv32i_types::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter bit          MISALIGNED_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [2:0]      req_funct3_i,
  output logic            mem_read_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_resp_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_misaligned_o,
  output logic            busy_o
);

  load_state_t     state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  load_funct3_t    funct3_q, funct3_d;
  logic            span_q, span_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] hi_q, hi_d;

  load_funct3_t    req_funct3;
  logic [2:0]      req_size;
  logic [3:0]      req_end;
  logic            req_span;
  logic            accept;
  logic            trap;
  logic [XLEN-1:0] lo_addr;
  logic [XLEN-1:0] hi_addr;
  logic [XLEN-1:0] ext_data;

  // Request decode
  assign req_funct3 = load_funct3_t'(req_funct3_i);
  assign req_size   = load_size(req_funct3);
  assign req_end    = {2'b00, req_addr_i[1:0]} + {1'b0, req_size};
  assign req_span   = (req_end > 4'd4);
  assign accept     = req_valid_i && (state_q == StIdle);

  assign trap    = span_q && !MISALIGNED_EN;
  assign lo_addr = {addr_q[XLEN-1:2], 2'b00};
  // Natural wrap: the word after 0xFFFF_FFFC is 0x0000_0000.
  assign hi_addr = lo_addr + XLEN'(4);

  // Next-state and latches
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    span_d   = span_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d   = req_addr_i;
          funct3_d = req_funct3;
          span_d   = req_span;
          // hi stays zero for non-spanning loads so extraction sees zeros above.
          lo_d     = '0;
          hi_d     = '0;
          state_d  = (req_span && !MISALIGNED_EN) ? StDone : StRd0;
        end
      end
      StRd0: begin
        if (mem_resp_i) begin
          lo_d    = mem_rdata_i;
          state_d = span_q ? StRd1 : StDone;
        end
      end
      StRd1: begin
        if (mem_resp_i) begin
          hi_d    = mem_rdata_i;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      funct3_q <= FnLb;
      span_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      span_q   <= span_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  load_extend #(
    .XLEN(XLEN)
  ) u_extend (
    .data_i  ({hi_q, lo_q}),
    .off_i   (addr_q[1:0]),
    .funct3_i(funct3_q),
    .data_o  (ext_data)
  );

  // Outputs are decoded from state and latched values only, so reset clears
  // them asynchronously and no req_* input reaches the memory port.
  always_comb begin
    mem_read_o       = 1'b0;
    mem_addr_o       = '0;
    rsp_valid_o      = 1'b0;
    rsp_data_o       = '0;
    rsp_misaligned_o = 1'b0;
    unique case (state_q)
      StRd0: begin
        mem_read_o = 1'b1;
        mem_addr_o = lo_addr;
      end
      StRd1: begin
        mem_read_o = 1'b1;
        mem_addr_o = hi_addr;
      end
      StDone: begin
        rsp_valid_o = 1'b1;
        if (trap) begin
          rsp_misaligned_o = 1'b1;
        end else begin
          rsp_data_o = ext_data;
        end
      end
      default: ;
    endcase
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        m_req_valid, t_req_valid;

  logic        m_req_ready, m_mem_read, m_rsp_valid, m_rsp_mis, m_busy;
  logic [31:0] m_mem_addr, m_rsp_data;
  logic        t_req_ready, t_mem_read, t_rsp_valid, t_rsp_mis, t_busy;
  logic [31:0] t_mem_addr, t_rsp_data;

  logic        use_trap;
  logic        o_req_ready, o_mem_read, o_rsp_valid, o_rsp_mis;
  logic [31:0] o_mem_addr, o_rsp_data;

  int n_checks;
  int n_errors;

  load_align_unit #(
    .XLEN(32),
    .MISALIGNED_EN(1'b1)
  ) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (m_req_valid),
    .req_ready_o     (m_req_ready),
    .req_addr_i      (req_addr),
    .req_funct3_i    (req_funct3),
    .mem_read_o      (m_mem_read),
    .mem_addr_o      (m_mem_addr),
    .mem_rdata_i     (mem_rdata),
    .mem_resp_i      (mem_resp),
    .rsp_valid_o     (m_rsp_valid),
    .rsp_data_o      (m_rsp_data),
    .rsp_misaligned_o(m_rsp_mis),
    .busy_o          (m_busy)
  );

  load_align_unit #(
    .XLEN(32),
    .MISALIGNED_EN(1'b0)
  ) u_trap (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (t_req_valid),
    .req_ready_o     (t_req_ready),
    .req_addr_i      (req_addr),
    .req_funct3_i    (req_funct3),
    .mem_read_o      (t_mem_read),
    .mem_addr_o      (t_mem_addr),
    .mem_rdata_i     (mem_rdata),
    .mem_resp_i      (mem_resp),
    .rsp_valid_o     (t_rsp_valid),
    .rsp_data_o      (t_rsp_data),
    .rsp_misaligned_o(t_rsp_mis),
    .busy_o          (t_busy)
  );

  assign o_req_ready = use_trap ? t_req_ready : m_req_ready;
  assign o_mem_read  = use_trap ? t_mem_read  : m_mem_read;
  assign o_mem_addr  = use_trap ? t_mem_addr  : m_mem_addr;
  assign o_rsp_valid = use_trap ? t_rsp_valid : m_rsp_valid;
  assign o_rsp_data  = use_trap ? t_rsp_data  : m_rsp_data;
  assign o_rsp_mis   = use_trap ? t_rsp_mis   : m_rsp_mis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model: byte-array view of the two words.
  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit ref_span(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) + ref_size(f3)) > 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] lo, input logic [31:0] hi);
    byte unsigned mem[8];
    int     size;
    int     off;
    longint val;
    for (int i = 0; i < 4; i++) begin
      mem[i]     = lo[8*i +: 8];
      mem[i + 4] = hi[8*i +: 8];
    end
    size = ref_size(f3);
    off  = int'(addr[1:0]);
    val  = 0;
    for (int i = 0; i < size; i++) val = val | (longint'(mem[off + i]) << (8 * i));
    if ((f3 == 3'd0 || f3 == 3'd1) && val[8*size-1]) val = val - (longint'(1) << (8 * size));
    return val[31:0];
  endfunction

  // Drives one request and acts as the cache: answers each read after 'waits'
  // idle cycles, returning lo for the load's base word and hi otherwise.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] lo,
                          input logic [31:0] hi, input int waits, output logic [31:0] data,
                          output logic mis, output int lat, output int nreads,
                          output logic [31:0] a0, output logic [31:0] a1, output int bad_hold);
    int          cyc;
    int          in_read;
    logic        prev_read;
    logic        prev_resp;
    logic        done;
    logic [31:0] prev_addr;
    data = 0; mis = 0; lat = -1; nreads = 0; a0 = 0; a1 = 0; bad_hold = 0;
    @(negedge clk);
    req_addr   = addr;
    req_funct3 = f3;
    if (use_trap) t_req_valid = 1'b1;
    else m_req_valid = 1'b1;
    chk("req_ready_before_accept", {31'd0, o_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    m_req_valid = 1'b0;
    t_req_valid = 1'b0;
    cyc = 1; prev_read = 0; prev_resp = 0; prev_addr = 0; in_read = 0; done = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (o_rsp_valid) begin
        data = o_rsp_data;
        mis  = o_rsp_mis;
        lat  = cyc;
        done = 1'b1;
        chk("done_mem_read_low", {31'd0, o_mem_read}, 32'd0);
        chk("done_not_ready", {31'd0, o_req_ready}, 32'd0);
      end else if (o_mem_read) begin
        if (!prev_read || prev_resp) begin
          nreads++;
          in_read = 0;
          if (nreads == 1) a0 = o_mem_addr;
          else a1 = o_mem_addr;
        end else if (o_mem_addr != prev_addr) begin
          bad_hold++;
        end
        if (in_read == waits) begin
          mem_resp  = 1'b1;
          mem_rdata = (o_mem_addr == {addr[31:2], 2'b00}) ? lo : hi;
        end else begin
          mem_rdata = $urandom;
        end
        in_read++;
      end
      prev_read = o_mem_read;
      prev_resp = mem_resp;
      prev_addr = o_mem_addr;
      if (!done) begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    mem_resp = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: no rsp_valid for addr %h funct3 %0d", addr, f3);
    end
  endtask

  task automatic check_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] lo, input logic [31:0] hi, input int waits,
                            input logic [31:0] exp_data, input logic exp_mis, input int exp_lat,
                            input int exp_reads);
    logic [31:0] data, a0, a1;
    logic        mis;
    int          lat, nreads, bad_hold;
    run_load(f3, addr, lo, hi, waits, data, mis, lat, nreads, a0, a1, bad_hold);
    chk({tag, "_data"}, data, exp_data);
    chk({tag, "_misaligned"}, {31'd0, mis}, {31'd0, exp_mis});
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_nreads"}, nreads, exp_reads);
    chk({tag, "_addr_hold"}, bad_hold, 0);
    if (exp_reads >= 1) chk({tag, "_addr0"}, a0, {addr[31:2], 2'b00});
    if (exp_reads == 2) chk({tag, "_addr1"}, a1, {addr[31:2], 2'b00} + 32'd4);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] lo;
    logic [31:0] hi;
    int          waits;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr, lo, hi;
    int          waits, sp;

    n_checks = 0; n_errors = 0;
    use_trap = 1'b0;
    rst_n = 1'b0;
    m_req_valid = 1'b0; t_req_valid = 1'b0;
    req_addr = '0; req_funct3 = '0; mem_rdata = '0; mem_resp = 1'b0;

    vecs[0] = '{3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 32'hDEAD_BEEF};
    vecs[1] = '{3'd0, 32'h0000_0103, 32'h80FF_0000, 32'h0, 0, 32'hFFFF_FF80};
    vecs[2] = '{3'd4, 32'h0000_0103, 32'h80FF_0000, 32'h0, 0, 32'h0000_0080};
    vecs[3] = '{3'd1, 32'h0000_0103, 32'hAB00_0000, 32'h0000_00CD, 0, 32'hFFFF_CDAB};
    vecs[4] = '{3'd2, 32'hFFFF_FFFE, 32'h5678_0000, 32'h0000_1234, 3, 32'h1234_5678};
    vecs[5] = '{3'd3, 32'h0000_0100, 32'h1122_3344, 32'h0, 1, 32'h1122_3344};
    vecs[6] = '{3'd5, 32'h0000_0102, 32'h8001_0000, 32'h0, 0, 32'h0000_8001};
    vecs[7] = '{3'd1, 32'h0000_0102, 32'h8001_0000, 32'h0, 2, 32'hFFFF_8001};
    vecs[8] = '{3'd0, 32'h0000_0101, 32'h0000_7F00, 32'h0, 0, 32'h0000_007F};
    vecs[9] = '{3'd2, 32'h0000_0101, 32'hDDCC_BBAA, 32'h0000_00EE, 1, 32'hEEDD_CCBB};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, m_req_ready}, 32'd1);
    chk("rst_busy", {31'd0, m_busy}, 32'd0);
    chk("rst_mem_read", {31'd0, m_mem_read}, 32'd0);
    chk("rst_mem_addr", m_mem_addr, 32'd0);
    chk("rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    chk("rst_rsp_data", m_rsp_data, 32'd0);
    chk("rst_rsp_mis", {31'd0, m_rsp_mis}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table on the splitting unit
    for (int i = 0; i < 10; i++) begin
      sp = ref_span(vecs[i].f3, vecs[i].addr) ? 1 : 0;
      check_load($sformatf("vec%0d", i), vecs[i].f3, vecs[i].addr, vecs[i].lo, vecs[i].hi,
                 vecs[i].waits, vecs[i].exp, 1'b0, 2 + sp + vecs[i].waits * (1 + sp), 1 + sp);
    end

    // Trapping unit: spanning loads never touch memory
    use_trap = 1'b1;
    check_load("trap_lw", 3'd2, 32'h0000_0102, 32'h1234_5678, 32'h9ABC_DEF0, 0,
               32'h0, 1'b1, 1, 0);
    check_load("trap_lh", 3'd1, 32'h0000_0203, 32'hFF00_0000, 32'h0000_00FF, 0,
               32'h0, 1'b1, 1, 0);
    check_load("trap_unit_lbu", 3'd4, 32'h0000_0101, 32'h0000_F000, 32'h0, 0,
               32'h0000_00F0, 1'b0, 2, 1);
    use_trap = 1'b0;

    // Reset asserted during the second read of a spanning lw
    @(negedge clk);
    req_addr = 32'h0000_0103; req_funct3 = 3'd2; m_req_valid = 1'b1;
    @(posedge clk);
    #1 m_req_valid = 1'b0;
    @(negedge clk);
    chk("rstseq_rd0_read", {31'd0, m_mem_read}, 32'd1);
    mem_resp = 1'b1; mem_rdata = 32'h1111_1111;
    @(posedge clk);
    #1 mem_resp = 1'b0;
    @(negedge clk);
    chk("rstseq_rd1_read", {31'd0, m_mem_read}, 32'd1);
    chk("rstseq_rd1_addr", m_mem_addr, 32'h0000_0104);
    #2 rst_n = 1'b0;
    #1;
    chk("rstseq_mem_read_drop", {31'd0, m_mem_read}, 32'd0);
    chk("rstseq_busy_drop", {31'd0, m_busy}, 32'd0);
    chk("rstseq_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstseq_ready", {31'd0, m_req_ready}, 32'd1);
    check_load("post_rst_lhu", 3'd5, 32'h0000_0200, 32'h0000_9ABC, 32'h0, 0,
               32'h0000_9ABC, 1'b0, 2, 1);

    // Random loads against the byte-level model
    for (int i = 0; i < 150; i++) begin
      f3    = 3'($urandom_range(0, 7));
      addr  = $urandom;
      lo    = $urandom;
      hi    = $urandom;
      waits = $urandom_range(0, 2);
      sp    = ref_span(f3, addr) ? 1 : 0;
      check_load($sformatf("rand%0d", i), f3, addr, lo, hi, waits, ref_load(f3, addr, lo, hi),
                 1'b0, 2 + sp + waits * (1 + sp), 1 + sp);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
